// File: rtl/tt_uart_pkg.sv
// Shared definitions for the Tiny Tapeout 8N1 UART receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_uart_pkg;

  // Receiver sequencing: hunt for a start bit, confirm it, shift data, check stop.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Bit positions of the status flags on uio_out.
  localparam int VALID = 0;
  localparam int FERR  = 1;
  localparam int OVR   = 2;
  localparam int BUSY  = 3;

  // Status nibble drives out; the upper nibble stays an input.
  localparam logic [7:0] UIO_OE_MASK = 8'h0F;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; the input is sampled every cycle.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
// RST_VAL sets the value both flops take in reset, so an idle-high line
// does not look like an edge when reset is released.
module tt_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_um_reuel_pandher_uart_rx.sv
// 8N1 UART receiver: byte on uo_out, valid/frame_err/overrun/busy on uio_out[3:0].
// Latency: rx start edge to valid = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
// Backpressure: none; an unacknowledged byte is overwritten and overrun is raised.
// Ports: ui_in[0] rx (idle high), ui_in[1] rd_ack (rising edge clears flags),
//        uo_out last good byte, uio_out status flags, uio_oe fixed 8'h0F,
//        ena low parks the receiver in IDLE, uio_in and ui_in[7:2] unused.
module tt_um_reuel_pandher_uart_rx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic        rx_s;
  logic        ack_s;
  logic        ack_q;
  logic        ack_rise;
  uart_state_t state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        half_hit;
  logic        bit_hit;
  logic        stop_evt;

  tt_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[0]),
    .q     (rx_s)
  );

  tt_sync2 #(.RST_VAL(1'b0)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[1]),
    .q     (ack_s)
  );

  assign ack_rise = ack_s & ~ack_q;
  assign half_hit = (clk_cnt == HALF_LAST);
  assign bit_hit  = (clk_cnt == BIT_LAST);
  // Stop-bit sample point; the flag logic keys off this single cycle.
  assign stop_evt = ena && (state == STOP) && bit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!ena) begin
      // Any partial frame is abandoned; the line is re-hunted once enabled.
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (half_hit) begin
            clk_cnt <= '0;
            // A line already back high at mid start bit was noise.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            // 3-bit counter wraps 7->0 as the frame moves on to STOP.
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An ack arriving on the same cycle as a stop sample belongs to the previous
  // byte: it clears the old flags, then the new byte's outcome is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ack_q <= ack_s;
      if (stop_evt && rx_s) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
        ferr_q  <= 1'b0;
        ovr_q   <= ack_rise ? 1'b0 : (ovr_q | valid_q);
      end else if (stop_evt) begin
        ferr_q <= 1'b1;
        if (ack_rise) begin
          valid_q <= 1'b0;
          ovr_q   <= 1'b0;
        end
      end else if (ack_rise) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    uio_out        = '0;
    uio_out[VALID] = valid_q;
    uio_out[FERR]  = ferr_q;
    uio_out[OVR]   = ovr_q;
    uio_out[BUSY]  = (state != IDLE);
  end

  assign uo_out = data_q;
  assign uio_oe = UIO_OE_MASK;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7:2], uio_in};

endmodule
